// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Issues loads/stores on a req/ack data bus, aligns and extends load data,
// and registers the writeback triple for WB. Stalls upstream while a bus
// transaction is outstanding; flags misaligned accesses and bus timeouts.
module mem_stage #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      mem_write_enable,
   input  logic [REG_ADDR_WIDTH-1:0] mem_write_addr,
   input  logic [DATA_WIDTH-1:0]     mem_write_data,
   input  logic [3:0]                mem_op,
   input  logic [DATA_WIDTH-1:0]     mem_store_data,
   output logic                      dbus_req,
   output logic                      dbus_we,
   output logic [DATA_WIDTH-1:0]     dbus_addr,
   output logic [3:0]                dbus_byte_en,
   output logic [DATA_WIDTH-1:0]     dbus_wdata,
   input  logic                      dbus_ack,
   input  logic [DATA_WIDTH-1:0]     dbus_rdata,
   output logic                      stall_request,
   output logic                      wb_write_enable,
   output logic [REG_ADDR_WIDTH-1:0] wb_write_addr,
   output logic [DATA_WIDTH-1:0]     wb_write_data,
   output logic                      misaligned_error,
   output logic                      bus_error
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } op_t;

   state_t              state_q, state_n;
   logic [CNT_W-1:0]    count_q, count_n;
   logic [3:0]          op_q, op_n;
   logic [1:0]          lane_q, lane_n;

   logic                      req_n, we_n;
   logic [DATA_WIDTH-1:0]     addr_n, wdata_n;
   logic [3:0]                en_n;
   logic                      wb_en_n;
   logic [REG_ADDR_WIDTH-1:0] wb_addr_n;
   logic [DATA_WIDTH-1:0]     wb_data_n;
   logic                      mis_n, berr_n;

   logic                  is_load, is_store, is_byte, is_half, is_word, aligned;
   logic [3:0]            lane_en;
   logic [DATA_WIDTH-1:0] store_word;
   logic [DATA_WIDTH-1:0] load_shift, load_value;
   logic [15:0]           load_half;

   // Decode the incoming operation: access size, alignment, lanes and store data.
   always_comb begin
      is_byte    = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
      is_half    = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
      is_word    = (mem_op == OP_LW) || (mem_op == OP_SW);
      is_load    = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_LH) ||
                   (mem_op == OP_LHU) || (mem_op == OP_LW);
      is_store   = (mem_op == OP_SB) || (mem_op == OP_SH) || (mem_op == OP_SW);
      aligned    = is_byte || (is_half && !mem_write_data[0]) ||
                   (is_word && (mem_write_data[1:0] == 2'b00));
      lane_en    = 4'b0000;
      store_word = '0;
      if (is_byte) begin
         lane_en = 4'b0001 << mem_write_data[1:0];
      end else if (is_half) begin
         lane_en = mem_write_data[1] ? 4'b1100 : 4'b0011;
      end else if (is_word) begin
         lane_en = 4'b1111;
      end
      if (mem_op == OP_SB) begin
         store_word = {4{mem_store_data[7:0]}};
      end else if (mem_op == OP_SH) begin
         store_word = {2{mem_store_data[15:0]}};
      end else if (mem_op == OP_SW) begin
         store_word = mem_store_data;
      end
   end

   // Extract and extend load data using the op and lane captured at request time.
   always_comb begin
      load_shift = dbus_rdata >> {lane_q, 3'b000};
      load_half  = lane_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
      case (op_q)
         OP_LB:   load_value = {{24{load_shift[7]}}, load_shift[7:0]};
         OP_LBU:  load_value = {24'h000000, load_shift[7:0]};
         OP_LH:   load_value = {{16{load_half[15]}}, load_half};
         OP_LHU:  load_value = {16'h0000, load_half};
         default: load_value = dbus_rdata;
      endcase
   end

   // Next-state and registered-output values; stall is combinational and forced low in reset.
   always_comb begin
      state_n       = state_q;
      count_n       = count_q;
      op_n          = op_q;
      lane_n        = lane_q;
      req_n         = dbus_req;
      we_n          = dbus_we;
      addr_n        = dbus_addr;
      en_n          = dbus_byte_en;
      wdata_n       = dbus_wdata;
      wb_en_n       = wb_write_enable;
      wb_addr_n     = wb_write_addr;
      wb_data_n     = wb_write_data;
      mis_n         = 1'b0;
      berr_n        = 1'b0;
      stall_request = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_load || is_store) begin
               if (aligned) begin
                  stall_request = reset;
                  state_n       = BUSY;
                  count_n       = '0;
                  op_n          = mem_op;
                  lane_n        = mem_write_data[1:0];
                  req_n         = 1'b1;
                  we_n          = is_store;
                  addr_n        = {mem_write_data[DATA_WIDTH-1:2], 2'b00};
                  en_n          = lane_en;
                  wdata_n       = store_word;
                  wb_en_n       = 1'b0;
               end else begin
                  mis_n   = 1'b1;
                  wb_en_n = 1'b0;
               end
            end else begin
               wb_en_n   = mem_write_enable;
               wb_addr_n = mem_write_addr;
               wb_data_n = mem_write_data;
            end
         end
         BUSY: begin
            if (dbus_ack) begin
               // Ack beats timeout when both land on the same cycle.
               state_n = IDLE;
               req_n   = 1'b0;
               if (op_q == OP_SB || op_q == OP_SH || op_q == OP_SW) begin
                  wb_en_n = 1'b0;
               end else begin
                  wb_en_n   = mem_write_enable;
                  wb_addr_n = mem_write_addr;
                  wb_data_n = load_value;
               end
            end else if (count_q == CNT_LAST) begin
               state_n = IDLE;
               req_n   = 1'b0;
               berr_n  = 1'b1;
               wb_en_n = 1'b0;
            end else begin
               stall_request = reset;
               count_n       = count_q + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            req_n   = 1'b0;
         end
      endcase
   end

   // State, bus and writeback registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         count_q          <= '0;
         op_q             <= '0;
         lane_q           <= '0;
         dbus_req         <= 1'b0;
         dbus_we          <= 1'b0;
         dbus_addr        <= '0;
         dbus_byte_en     <= '0;
         dbus_wdata       <= '0;
         wb_write_enable  <= 1'b0;
         wb_write_addr    <= '0;
         wb_write_data    <= '0;
         misaligned_error <= 1'b0;
         bus_error        <= 1'b0;
      end else begin
         state_q          <= state_n;
         count_q          <= count_n;
         op_q             <= op_n;
         lane_q           <= lane_n;
         dbus_req         <= req_n;
         dbus_we          <= we_n;
         dbus_addr        <= addr_n;
         dbus_byte_en     <= en_n;
         dbus_wdata       <= wdata_n;
         wb_write_enable  <= wb_en_n;
         wb_write_addr    <= wb_addr_n;
         wb_write_data    <= wb_data_n;
         misaligned_error <= mis_n;
         bus_error        <= berr_n;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table driven through a bus
// responder, writeback results checked against a scoreboard queue.
module tb_mem_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mem_write_enable = 1'b0;
   logic [4:0]  mem_write_addr = '0;
   logic [31:0] mem_write_data = '0;
   logic [3:0]  mem_op = '0;
   logic [31:0] mem_store_data = '0;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic [3:0]  dbus_byte_en;
   logic        dbus_ack = 1'b0;
   logic [31:0] dbus_rdata = '0;
   logic        stall_request;
   logic        wb_write_enable;
   logic [4:0]  wb_write_addr;
   logic [31:0] wb_write_data;
   logic        misaligned_error, bus_error;

   int checks = 0;
   int failures = 0;

   mem_stage #(
      .DATA_WIDTH(32),
      .REG_ADDR_WIDTH(5),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .mem_write_enable(mem_write_enable),
      .mem_write_addr(mem_write_addr),
      .mem_write_data(mem_write_data),
      .mem_op(mem_op),
      .mem_store_data(mem_store_data),
      .dbus_req(dbus_req),
      .dbus_we(dbus_we),
      .dbus_addr(dbus_addr),
      .dbus_byte_en(dbus_byte_en),
      .dbus_wdata(dbus_wdata),
      .dbus_ack(dbus_ack),
      .dbus_rdata(dbus_rdata),
      .stall_request(stall_request),
      .wb_write_enable(wb_write_enable),
      .wb_write_addr(wb_write_addr),
      .wb_write_data(wb_write_data),
      .misaligned_error(misaligned_error),
      .bus_error(bus_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic        wren;
      logic [4:0]  waddr;
      int          delay;      // ack wait cycles; -1 = never ack
      logic [31:0] rdata;
      logic        exp_req;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [3:0]  exp_en;
      logic [31:0] exp_wdata;
      int          exp_stall;
      logic        exp_wb_en;
      logic        chk_wb_all; // also compare wb addr/data
      logic [31:0] exp_wb_data;
      logic        exp_mis;
      logic        exp_berr;
   } vec_t;

   typedef struct {
      logic        en;
      logic        full;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        mis;
      logic        berr;
   } sb_t;

   sb_t  sb[$];
   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_none(input logic wren, input logic [4:0] waddr, input logic [31:0] data);
      mem_op           = 4'd0;
      mem_write_enable = wren;
      mem_write_addr   = waddr;
      mem_write_data   = data;
      mem_store_data   = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      sb_t e;
      sb_t got;
      int  stalls;
      int  n;
      e.en   = v.exp_wb_en;
      e.full = v.chk_wb_all;
      e.addr = v.waddr;
      e.data = v.exp_wb_data;
      e.mis  = v.exp_mis;
      e.berr = v.exp_berr;
      sb.push_back(e);

      mem_op           = v.op;
      mem_write_enable = v.wren;
      mem_write_addr   = v.waddr;
      mem_write_data   = v.addr;
      mem_store_data   = v.sdata;
      dbus_ack         = 1'b0;
      #1;
      stalls = stall_request ? 1 : 0;
      @(posedge clock); #1;

      if (v.exp_req) begin
         check($sformatf("v%0d_req", idx), 32'(dbus_req), 32'd1);
         check($sformatf("v%0d_we", idx), 32'(dbus_we), 32'(v.exp_we));
         check($sformatf("v%0d_addr", idx), dbus_addr, v.exp_addr);
         check($sformatf("v%0d_en", idx), 32'(dbus_byte_en), 32'(v.exp_en));
         check($sformatf("v%0d_wdata", idx), dbus_wdata, v.exp_wdata);
         if (v.delay >= 0) begin
            for (int w = 0; w < v.delay; w++) begin
               if (stall_request) stalls++;
               @(posedge clock); #1;
               check($sformatf("v%0d_hold_addr", idx), dbus_addr, v.exp_addr);
            end
            dbus_ack   = 1'b1;
            dbus_rdata = v.rdata;
            #1;
            check($sformatf("v%0d_ack_stall", idx), 32'(stall_request), 32'd0);
            @(posedge clock); #1;
            dbus_ack   = 1'b0;
            dbus_rdata = '0;
         end else begin
            n = 0;
            while (dbus_req && n < 20) begin
               if (stall_request) stalls++;
               @(posedge clock); #1;
               n++;
            end
            check($sformatf("v%0d_timeout_bound", idx), 32'(n < 20), 32'd1);
         end
      end

      check($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'(v.exp_stall));
      check($sformatf("v%0d_req_low", idx), 32'(dbus_req), 32'd0);

      if (sb.size() == 0) begin
         check($sformatf("v%0d_sb_empty", idx), 32'd1, 32'd0);
      end else begin
         got = sb.pop_front();
         check($sformatf("v%0d_wb_en", idx), 32'(wb_write_enable), 32'(got.en));
         if (got.full) begin
            check($sformatf("v%0d_wb_addr", idx), 32'(wb_write_addr), 32'(got.addr));
            check($sformatf("v%0d_wb_data", idx), wb_write_data, got.data);
         end
         check($sformatf("v%0d_mis", idx), 32'(misaligned_error), 32'(got.mis));
         check($sformatf("v%0d_berr", idx), 32'(bus_error), 32'(got.berr));
      end

      // one idle cycle: error flags must already be gone
      drive_none(1'b0, 5'd0, 32'd0);
      @(posedge clock); #1;
      check($sformatf("v%0d_mis_pulse", idx), 32'(misaligned_error), 32'd0);
      check($sformatf("v%0d_berr_pulse", idx), 32'(bus_error), 32'd0);
   endtask

   initial begin
      //           op     addr          sdata         wren  waddr  dly rdata         req   we    exp_addr      en       wdata         stl wben  all   wb_data       mis   berr
      vecs[0]  = '{4'd0,  32'hDEADBEEF, 32'h0,        1'b1, 5'd5,  0,  32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        0,  1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[1]  = '{4'd1,  32'h00001003, 32'h0,        1'b1, 5'd7,  2,  32'h80FFFF7F, 1'b1, 1'b0, 32'h00001000, 4'b1000, 32'h0,        3,  1'b1, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0};
      vecs[2]  = '{4'd2,  32'h00001003, 32'h0,        1'b1, 5'd8,  2,  32'h80FFFF7F, 1'b1, 1'b0, 32'h00001000, 4'b1000, 32'h0,        3,  1'b1, 1'b1, 32'h00000080, 1'b0, 1'b0};
      vecs[3]  = '{4'd7,  32'h00002002, 32'h1234ABCD, 1'b0, 5'd0,  0,  32'h0,        1'b1, 1'b1, 32'h00002000, 4'b1100, 32'hABCDABCD, 1,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[4]  = '{4'd5,  32'h00003001, 32'h0,        1'b1, 5'd9,  0,  32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        0,  1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
      vecs[5]  = '{4'd5,  32'h00004000, 32'h0,        1'b1, 5'd10, -1, 32'h0,        1'b1, 1'b0, 32'h00004000, 4'b1111, 32'h0,        4,  1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
      vecs[6]  = '{4'd3,  32'h00005002, 32'h0,        1'b1, 5'd11, 1,  32'h80017FFF, 1'b1, 1'b0, 32'h00005000, 4'b1100, 32'h0,        2,  1'b1, 1'b1, 32'hFFFF8001, 1'b0, 1'b0};
      vecs[7]  = '{4'd4,  32'h00005000, 32'h0,        1'b1, 5'd12, 0,  32'h8001F00F, 1'b1, 1'b0, 32'h00005000, 4'b0011, 32'h0,        1,  1'b1, 1'b1, 32'h0000F00F, 1'b0, 1'b0};
      vecs[8]  = '{4'd6,  32'h00006001, 32'h000000A5, 1'b0, 5'd0,  1,  32'h0,        1'b1, 1'b1, 32'h00006000, 4'b0010, 32'hA5A5A5A5, 2,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[9]  = '{4'd8,  32'h00007000, 32'hCAFEF00D, 1'b0, 5'd0,  0,  32'h0,        1'b1, 1'b1, 32'h00007000, 4'b1111, 32'hCAFEF00D, 1,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[10] = '{4'd5,  32'h00008004, 32'h0,        1'b1, 5'd0,  3,  32'h13579BDF, 1'b1, 1'b0, 32'h00008004, 4'b1111, 32'h0,        4,  1'b1, 1'b1, 32'h13579BDF, 1'b0, 1'b0};
      vecs[11] = '{4'd7,  32'h00009001, 32'h0000FFFF, 1'b0, 5'd0,  0,  32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        0,  1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
      vecs[12] = '{4'd15, 32'h11111111, 32'h0,        1'b0, 5'd3,  0,  32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        0,  1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0};
      vecs[13] = '{4'd1,  32'h00000000, 32'h0,        1'b1, 5'd4,  0,  32'h0000007F, 1'b1, 1'b0, 32'h00000000, 4'b0001, 32'h0,        1,  1'b1, 1'b1, 32'h0000007F, 1'b0, 1'b0};

      // reset state
      #3;
      check("rst_req", 32'(dbus_req), 32'd0);
      check("rst_stall", 32'(stall_request), 32'd0);
      check("rst_wb_en", 32'(wb_write_enable), 32'd0);
      check("rst_wb_data", wb_write_data, 32'd0);
      check("rst_errs", 32'({misaligned_error, bus_error}), 32'd0);
      #9 reset = 1'b1;
      @(posedge clock); #1;

      for (int i = 0; i < 14; i++) begin
         run_vec(vecs[i], i);
      end

      // ack while idle is ignored
      drive_none(1'b1, 5'd9, 32'h00000055);
      dbus_ack = 1'b1;
      #1;
      check("idle_ack_stall", 32'(stall_request), 32'd0);
      @(posedge clock); #1;
      dbus_ack = 1'b0;
      check("idle_ack_req", 32'(dbus_req), 32'd0);
      check("idle_ack_wb_data", wb_write_data, 32'h00000055);
      check("idle_ack_wb_addr", 32'(wb_write_addr), 32'd9);

      // reset in the middle of a bus transaction
      mem_op           = 4'd5;
      mem_write_enable = 1'b1;
      mem_write_addr   = 5'd2;
      mem_write_data   = 32'h00000100;
      @(posedge clock); #1;
      check("midrst_req_before", 32'(dbus_req), 32'd1);
      reset = 1'b0;
      #1;
      check("midrst_req", 32'(dbus_req), 32'd0);
      check("midrst_stall", 32'(stall_request), 32'd0);
      check("midrst_wb_en", 32'(wb_write_enable), 32'd0);
      check("midrst_wb_data", wb_write_data, 32'd0);
      drive_none(1'b1, 5'd6, 32'h0000A5A5);
      #2 reset = 1'b1;
      #1;
      check("post_rst_stall", 32'(stall_request), 32'd0);
      @(posedge clock); #1;
      check("post_rst_wb_en", 32'(wb_write_enable), 32'd1);
      check("post_rst_wb_addr", 32'(wb_write_addr), 32'd6);
      check("post_rst_wb_data", wb_write_data, 32'h0000A5A5);
      check("post_rst_req", 32'(dbus_req), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
